// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the three-phase async SRAM arbiter.
package sram_arb_pkg;
  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
  typedef enum logic [1:0] {NONE, CPU, VID, LDR} req_id_t;
endpackage

// File: rtl/sram_arb_sel.sv
// Combinational grant selector: loader > video > CPU, but the CPU wins
// right after a video grant so a streaming video port cannot starve it.
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    vid_req_i,
  input  logic    ldr_req_i,
  input  req_id_t last_i,
  output req_id_t grant_o
);

  always_comb begin
    grant_o = NONE;
    if (ldr_req_i) begin
      grant_o = LDR;
    end else if (cpu_req_i && (last_i == VID)) begin
      grant_o = CPU;
    end else if (vid_req_i) begin
      grant_o = VID;
    end else if (cpu_req_i) begin
      grant_o = CPU;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Async SRAM arbiter: IDLE->SETUP->STROBE per access, ack 3 cycles after grant, one access per 3 cycles;
// requesters hold req until ack. Optional write-only loader port under `SRAM_ARB_LOADER_EN.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [SRAM_AW-1:0] cpu_addr,
  input  logic [SRAM_DW-1:0] cpu_wdata,
  output logic               cpu_ack,
  output logic [SRAM_DW-1:0] cpu_rdata,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [SRAM_DW-1:0] vid_rdata,
`ifdef SRAM_ARB_LOADER_EN
  input  logic               ldr_req,
  input  logic [SRAM_AW-1:0] ldr_addr,
  input  logic [SRAM_DW-1:0] ldr_wdata,
  output logic               ldr_ack,
`endif
  output logic [SRAM_AW-1:0] sram_addr_o,
  inout  wire  [SRAM_DW-1:0] sram_data_io,
  output logic               sram_we_n_o,
  output logic               sram_oe_n_o,
  output logic               busy
);

  state_t             state_q, state_d;
  req_id_t            last_q, last_d, grant;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic [SRAM_DW-1:0] cpu_rdata_q, vid_rdata_q;
  logic               ldr_req_w;

`ifdef SRAM_ARB_LOADER_EN
  logic ldr_ack_q, ldr_ack_d;
  assign ldr_req_w = ldr_req;
  assign ldr_ack   = ldr_ack_q;
`else
  assign ldr_req_w = 1'b0;
`endif

  sram_arb_sel u_sel (
    .cpu_req_i (cpu_req),
    .vid_req_i (vid_req),
    .ldr_req_i (ldr_req_w),
    .last_i    (last_q),
    .grant_o   (grant)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cpu_ack_d = 1'b0;
    vid_ack_d = 1'b0;
`ifdef SRAM_ARB_LOADER_EN
    ldr_ack_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant != NONE) begin
          state_d = SETUP;
          last_d  = grant;
          case (grant)
            CPU: begin
              addr_d  = cpu_addr;
              wdata_d = cpu_wdata;
              we_d    = cpu_we;
            end
            VID: begin
              addr_d = vid_addr;
              we_d   = 1'b0;
            end
`ifdef SRAM_ARB_LOADER_EN
            LDR: begin
              addr_d  = ldr_addr;
              wdata_d = ldr_wdata;
              we_d    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        // last_q still names the owner of the access that is finishing
        state_d   = IDLE;
        cpu_ack_d = (last_q == CPU);
        vid_ack_d = (last_q == VID);
`ifdef SRAM_ARB_LOADER_EN
        ldr_ack_d = (last_q == LDR);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cpu_ack_q <= cpu_ack_d;
      vid_ack_q <= vid_ack_d;
      if (state_q == STROBE && !we_q) begin
        if (last_q == CPU) cpu_rdata_q <= sram_data_io;
        if (last_q == VID) vid_rdata_q <= sram_data_io;
      end
    end
  end

`ifdef SRAM_ARB_LOADER_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ldr_ack_q <= 1'b0;
    else       ldr_ack_q <= ldr_ack_d;
  end
`endif

  // STROBE releases we_n while data is still driven to give one cycle of hold
  assign busy         = (state_q != IDLE);
  assign sram_addr_o  = addr_q;
  assign sram_we_n_o  = !((state_q == SETUP) && we_q);
  assign sram_oe_n_o  = !((state_q != IDLE) && !we_q);
  assign sram_data_io = ((state_q != IDLE) && we_q) ? wdata_q : {SRAM_DW{1'bz}};
  assign cpu_ack      = cpu_ack_q;
  assign vid_ack      = vid_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign vid_rdata    = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the data bus.
module tb_sram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req;
  logic [18:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
`ifdef SRAM_ARB_LOADER_EN
  logic        ldr_req;
  logic [18:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_ack;
`endif
  logic [18:0] sram_addr;
  wire  [7:0]  sram_data;
  logic        sram_we_n, sram_oe_n, busy;

  logic [7:0]  mem [0:524287];
  logic        pre_en;
  logic [18:0] pre_addr;
  logic [7:0]  pre_dat;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  sram_arbiter dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_ack      (vid_ack),
    .vid_rdata    (vid_rdata),
`ifdef SRAM_ARB_LOADER_EN
    .ldr_req      (ldr_req),
    .ldr_addr     (ldr_addr),
    .ldr_wdata    (ldr_wdata),
    .ldr_ack      (ldr_ack),
`endif
    .sram_addr_o  (sram_addr),
    .sram_data_io (sram_data),
    .sram_we_n_o  (sram_we_n),
    .sram_oe_n_o  (sram_oe_n),
    .busy         (busy)
  );

  assign sram_data = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 8'hzz;

  always @(posedge clk_sys) begin
    if (pre_en)          mem[pre_addr]  <= pre_dat;
    else if (!sram_we_n) mem[sram_addr] <= sram_data;
  end

  task automatic preload(input logic [18:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_en   = 1'b1;
    @(negedge clk_sys);
    pre_en   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b want=1", sram_oe_n); end
    checks++; if (sram_addr !== 19'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
    checks++; if ({cpu_ack, vid_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b want=00", {cpu_ack, vid_ack}); end
    checks++; if ({cpu_rdata, vid_rdata} !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0000", {cpu_rdata, vid_rdata}); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_read;
    int oe_cnt = 0, ack_at = 0, vacks = 0, cacks = 0;
    vid_addr = 19'h12345;
    vid_req  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_sys);
      if (!sram_oe_n) oe_cnt++;
      if (i == 1) begin
        checks++; if (sram_addr !== 19'h12345 || sram_we_n !== 1'b1 || busy !== 1'b1) begin
          failures++; $display("FAIL read_setup addr=%h we_n=%b busy=%b want 12345/1/1", sram_addr, sram_we_n, busy);
        end
      end
      if (cpu_ack) cacks++;
      if (vid_ack) begin
        vacks++;
        if (ack_at == 0) ack_at = i;
        vid_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    checks++; if (oe_cnt != 2) begin failures++; $display("FAIL read_oe_cycles got=%0d want=2", oe_cnt); end
    checks++; if (ack_at != 3) begin failures++; $display("FAIL read_ack_latency got=%0d want=3", ack_at); end
    checks++; if (vacks != 1 || cacks != 0) begin failures++; $display("FAIL read_ack_count vid=%0d cpu=%0d want 1/0", vacks, cacks); end
    checks++; if (vid_rdata !== 8'hA5) begin failures++; $display("FAIL read_data got=%h want=a5", vid_rdata); end
  endtask

  task automatic test_write;
    int we_cnt = 0, we_at = 0, ack_at = 0;
    cpu_we    = 1'b1;
    cpu_addr  = 19'h7FFFF;
    cpu_wdata = 8'h3C;
    cpu_req   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_sys);
      if (!sram_we_n) begin we_cnt++; if (we_at == 0) we_at = i; end
      if (i <= 2) begin
        checks++; if (sram_data !== 8'h3C || sram_oe_n !== 1'b1 || sram_addr !== 19'h7FFFF) begin
          failures++; $display("FAIL write_bus_c%0d data=%h oe_n=%b addr=%h want 3c/1/7ffff", i, sram_data, sram_oe_n, sram_addr);
        end
      end
      if (cpu_ack) begin
        if (ack_at == 0) ack_at = i;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    checks++; if (we_cnt != 1 || we_at != 1) begin failures++; $display("FAIL write_we_pulse cnt=%0d at=%0d want 1/1", we_cnt, we_at); end
    checks++; if (ack_at != 3) begin failures++; $display("FAIL write_ack_latency got=%0d want=3", ack_at); end
    checks++; if (mem[19'h7FFFF] !== 8'h3C) begin failures++; $display("FAIL write_mem got=%h want=3c", mem[19'h7FFFF]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int at [2] = '{0, 0};
    cpu_we   = 1'b0;
    cpu_addr = 19'h7FFFF;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_sys);
      if (i == 3) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_ack_cycle_busy got=%b want=0", busy); end
      end
      if (i == 4) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_regrant_busy got=%b want=1", busy); end
      end
      if (cpu_ack) begin
        if (n < 2) at[n] = i;
        n++;
        if (n == 2) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    checks++; if (n != 2 || at[0] != 3 || at[1] != 6) begin
      failures++; $display("FAIL b2b_acks n=%0d at=%0d,%0d want 2 at 3,6", n, at[0], at[1]);
    end
    checks++; if (cpu_rdata !== 8'h3C) begin failures++; $display("FAIL b2b_rdata got=%h want=3c", cpu_rdata); end
  endtask

  task automatic test_contention;
    int n = 0, dbl = 0;
    int ids [4] = '{0, 0, 0, 0};
    int pos [4] = '{0, 0, 0, 0};
    int exp_ids [4] = '{2, 1, 2, 1};
    int exp_pos [4] = '{3, 6, 9, 12};
    vid_addr = 19'h00010;
    cpu_addr = 19'h00020;
    cpu_we   = 1'b0;
    vid_req  = 1'b1;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_sys);
      if (cpu_ack && vid_ack) dbl++;
      if (cpu_ack || vid_ack) begin
        if (n < 4) begin ids[n] = vid_ack ? 2 : 1; pos[n] = i; end
        n++;
        if (n == 4) begin vid_req = 1'b0; cpu_req = 1'b0; end
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    checks++; if (n != 4 || dbl != 0) begin failures++; $display("FAIL cont_ack_count n=%0d double=%0d want 4/0", n, dbl); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ids[k] != exp_ids[k] || pos[k] != exp_pos[k]) begin
        failures++; $display("FAIL cont_grant%0d id=%0d at=%0d want id=%0d at=%0d", k, ids[k], pos[k], exp_ids[k], exp_pos[k]);
      end
    end
    checks++; if (vid_rdata !== 8'h11 || cpu_rdata !== 8'h22) begin
      failures++; $display("FAIL cont_rdata vid=%h cpu=%h want 11/22", vid_rdata, cpu_rdata);
    end
  endtask

  task automatic test_dropped;
    int n = 0, ack_at = 0, busy_cnt = 0;
    cpu_we   = 1'b0;
    cpu_addr = 19'h00042;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_sys);
      if (i == 1) cpu_req = 1'b0;
      if (busy) busy_cnt++;
      if (cpu_ack) begin n++; if (ack_at == 0) ack_at = i; end
    end
    checks++; if (n != 1 || ack_at != 3) begin failures++; $display("FAIL drop_ack n=%0d at=%0d want 1 at 3", n, ack_at); end
    checks++; if (busy_cnt != 2) begin failures++; $display("FAIL drop_busy_cycles got=%0d want=2", busy_cnt); end
    checks++; if (cpu_rdata !== 8'h5A) begin failures++; $display("FAIL drop_rdata got=%h want=5a", cpu_rdata); end
  endtask

  task automatic test_reset_mid;
    int n = 0, ack_at = 0;
    cpu_we    = 1'b1;
    cpu_addr  = 19'h00100;
    cpu_wdata = 8'h77;
    cpu_req   = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++; if (busy !== 1'b1 || sram_addr !== 19'h00100) begin
      failures++; $display("FAIL rstmid_strobe busy=%b addr=%h want 1/00100", busy, sram_addr);
    end
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== 19'h0) begin
      failures++; $display("FAIL rstmid_pins busy=%b we_n=%b oe_n=%b addr=%h want 0/1/1/0", busy, sram_we_n, sram_oe_n, sram_addr);
    end
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL rstmid_rdata got=%h want=00", cpu_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) n++;
      if (i == 1) reset = 1'b0;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL rstmid_no_ack got=%0d want=0", n); end
    cpu_we   = 1'b0;
    cpu_addr = 19'h7FFFF;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin n++; if (ack_at == 0) ack_at = i; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    checks++; if (n != 1 || ack_at != 3 || cpu_rdata !== 8'h3C) begin
      failures++; $display("FAIL rstmid_recover n=%0d at=%0d rdata=%h want 1/3/3c", n, ack_at, cpu_rdata);
    end
  endtask

`ifdef SRAM_ARB_LOADER_EN
  task automatic test_loader;
    int n = 0, nl = 0, dbl = 0;
    int ids [4] = '{0, 0, 0, 0};
    int pos [4] = '{0, 0, 0, 0};
    int exp_ids [4] = '{3, 3, 2, 1};
    int exp_pos [4] = '{3, 6, 9, 12};
    ldr_addr  = 19'h00200;
    ldr_wdata = 8'h99;
    vid_addr  = 19'h00010;
    cpu_addr  = 19'h00020;
    cpu_we    = 1'b0;
    ldr_req   = 1'b1;
    vid_req   = 1'b1;
    cpu_req   = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_sys);
      if (int'(cpu_ack) + int'(vid_ack) + int'(ldr_ack) > 1) dbl++;
      if (cpu_ack || vid_ack || ldr_ack) begin
        if (n < 4) begin ids[n] = ldr_ack ? 3 : (vid_ack ? 2 : 1); pos[n] = i; end
        n++;
        if (ldr_ack) begin nl++; if (nl == 2) ldr_req = 1'b0; end
        if (n == 4) begin vid_req = 1'b0; cpu_req = 1'b0; end
      end
    end
    ldr_req = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    checks++; if (n != 4 || dbl != 0) begin failures++; $display("FAIL ldr_ack_count n=%0d double=%0d want 4/0", n, dbl); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ids[k] != exp_ids[k] || pos[k] != exp_pos[k]) begin
        failures++; $display("FAIL ldr_grant%0d id=%0d at=%0d want id=%0d at=%0d", k, ids[k], pos[k], exp_ids[k], exp_pos[k]);
      end
    end
    checks++; if (mem[19'h00200] !== 8'h99) begin failures++; $display("FAIL ldr_mem got=%h want=99", mem[19'h00200]); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
`ifdef SRAM_ARB_LOADER_EN
    ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0;
`endif
    pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
    test_reset();
    preload(19'h12345, 8'hA5);
    preload(19'h00010, 8'h11);
    preload(19'h00020, 8'h22);
    preload(19'h00042, 8'h5A);
    test_read();
    test_write();
    test_back_to_back();
    test_contention();
    test_dropped();
    test_reset_mid();
`ifdef SRAM_ARB_LOADER_EN
    test_loader();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
